// File: rtl/dsp_stim_pkg.sv
// Shared types and constants for the stimulus generator and its PRBS source.
package dsp_stim_pkg;

    typedef enum logic [2:0] {
        MODE_IMPULSE = 3'd0,
        MODE_STEP    = 3'd1,
        MODE_RAMP    = 3'd2,
        MODE_PRBS    = 3'd3,
        MODE_SQUARE  = 3'd4
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Taps for x^16 + x^14 + x^13 + x^11 + 1, i.e. state bits 15, 13, 12, 10.
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/dsp_stim_gen_lfsr16.sv
// 16-bit Fibonacci LFSR used as the PRBS pattern source.
module lfsr16
    import dsp_stim_pkg::*;
#(
    parameter logic [15:0] gp_seed = LFSR_DEFAULT_SEED
) (
    input  logic        i_clk,
    input  logic        i_rst_an,
    input  logic        i_load,
    input  logic [15:0] i_seed,
    input  logic        i_advance,
    output logic [15:0] o_state
);

    logic [15:0] state_q;
    logic [15:0] state_d;
    logic        feedback;

    // Shift left, feeding the XOR of the tapped bits into bit 0; a load wins over an advance.
    always_comb begin
        feedback = ^(state_q & LFSR_TAPS);
        state_d  = state_q;
        if (i_load) begin
            state_d = i_seed;
        end else if (i_advance) begin
            state_d = {state_q[14:0], feedback};
        end
    end

    // State register; a non-zero reset value keeps the LFSR out of its lock-up state.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            state_q <= gp_seed;
        end else begin
            // NOTE: sequential state always uses non-blocking assignment so every register samples pre-edge values.
            state_q <= state_d;
        end
    end

    assign o_state = state_q;

endmodule

// File: rtl/dsp_stim_gen.sv
// Built-in stimulus source: emits a bounded run of signed test samples, one per i_ena cycle.
module dsp_stim_gen
    import dsp_stim_pkg::*;
#(
    parameter int          gp_oup_width = 8,
    parameter int          gp_cnt_width = 16,
    parameter logic [15:0] gp_lfsr_seed = LFSR_DEFAULT_SEED
) (
    input  logic                           i_clk,
    input  logic                           i_rst_an,
    input  logic                           i_ena,
    input  logic                           i_start,
    input  logic [2:0]                     i_mode,
    input  logic [gp_cnt_width-1:0]        i_nr_samples,
    input  logic [gp_cnt_width-1:0]        i_period,
    output logic signed [gp_oup_width-1:0] o_data,
    output logic                           o_valid,
    output logic                           o_busy,
    output logic                           o_done,
    output logic [gp_cnt_width-1:0]        o_sample_cnt
);

    localparam int W = gp_oup_width;
    localparam int C = gp_cnt_width;

    localparam logic [W-1:0] MAX     = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] NEG_MAX = {1'b1, {(W-2){1'b0}}, 1'b1};
    localparam logic [C-1:0] CNT_ONE = {{(C-1){1'b0}}, 1'b1};

    state_e         state_q, state_d;
    logic [2:0]     mode_q, mode_d;
    logic [C-1:0]   nr_q, nr_d;
    logic [C-1:0]   period_q, period_d;
    logic [C-1:0]   cnt_q, cnt_d;
    logic [C-1:0]   sq_cnt_q, sq_cnt_d;
    logic           sq_neg_q, sq_neg_d;
    logic [W-1:0]   data_q, data_d;
    logic           valid_q, valid_d;
    logic           done_q, done_d;

    logic [C-1:0]   cnt_inc;
    logic [C-1:0]   sq_cnt_inc;
    logic [W-1:0]   sample;
    logic           lfsr_load;
    logic           lfsr_advance;
    logic [15:0]    lfsr_state;

    lfsr16 #(
        .gp_seed (gp_lfsr_seed)
    ) u_lfsr (
        .i_clk     (i_clk),
        .i_rst_an  (i_rst_an),
        .i_load    (lfsr_load),
        .i_seed    (gp_lfsr_seed),
        .i_advance (lfsr_advance),
        .o_state   (lfsr_state)
    );

    assign cnt_inc    = cnt_q + CNT_ONE;
    assign sq_cnt_inc = sq_cnt_q + CNT_ONE;

    // Pattern mux: value of sample k = cnt_q for the latched mode.
    always_comb begin
        sample = '0;
        case (mode_q)
            MODE_IMPULSE: sample = (cnt_q == '0) ? MAX : '0;
            MODE_STEP:    sample = MAX;
            MODE_RAMP:    sample = cnt_q[W-1:0];
            MODE_PRBS:    sample = lfsr_state[W-1:0];
            MODE_SQUARE:  sample = sq_neg_q ? NEG_MAX : MAX;
            default:      sample = '0;
        endcase
    end

    // Next-state and output logic of the run controller.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d      = state_q;
        mode_d       = mode_q;
        nr_d         = nr_q;
        period_d     = period_q;
        cnt_d        = cnt_q;
        sq_cnt_d     = sq_cnt_q;
        sq_neg_d     = sq_neg_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        done_d       = 1'b0;
        lfsr_load    = 1'b0;
        lfsr_advance = 1'b0;
        case (state_q)
            ST_IDLE: begin
                data_d = '0;
                if (i_start) begin
                    mode_d    = i_mode;
                    nr_d      = i_nr_samples;
                    period_d  = (i_period == '0) ? CNT_ONE : i_period;
                    cnt_d     = '0;
                    sq_cnt_d  = '0;
                    sq_neg_d  = 1'b0;
                    lfsr_load = 1'b1;
                    state_d   = (i_nr_samples == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_ena) begin
                    data_d       = sample;
                    valid_d      = 1'b1;
                    cnt_d        = cnt_inc;
                    lfsr_advance = 1'b1;
                    if (sq_cnt_inc == period_q) begin
                        sq_cnt_d = '0;
                        sq_neg_d = ~sq_neg_q;
                    end else begin
                        sq_cnt_d = sq_cnt_inc;
                    end
                    if (cnt_inc == nr_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                data_d  = '0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                data_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched run parameters and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            state_q  <= ST_IDLE;
            mode_q   <= '0;
            nr_q     <= '0;
            period_q <= '0;
            cnt_q    <= '0;
            sq_cnt_q <= '0;
            sq_neg_q <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            nr_q     <= nr_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            sq_cnt_q <= sq_cnt_d;
            sq_neg_q <= sq_neg_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    assign o_data       = data_q;
    assign o_valid      = valid_q;
    assign o_busy       = (state_q != ST_IDLE);
    assign o_done       = done_q;
    assign o_sample_cnt = cnt_q;

endmodule

// File: tb/tb_dsp_stim_gen.sv
// Directed self-checking bench for dsp_stim_gen at the default 8-bit sample width.
module tb_dsp_stim_gen;

    logic              i_clk;
    logic              i_rst_an;
    logic              i_ena;
    logic              i_start;
    logic [2:0]        i_mode;
    logic [15:0]       i_nr_samples;
    logic [15:0]       i_period;
    logic signed [7:0] o_data;
    logic              o_valid;
    logic              o_busy;
    logic              o_done;
    logic [15:0]       o_sample_cnt;

    int checks;
    int errors;

    dsp_stim_gen #(
        .gp_oup_width (8),
        .gp_cnt_width (16),
        .gp_lfsr_seed (16'hACE1)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_an     (i_rst_an),
        .i_ena        (i_ena),
        .i_start      (i_start),
        .i_mode       (i_mode),
        .i_nr_samples (i_nr_samples),
        .i_period     (i_period),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_sample_cnt (o_sample_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 1 time unit past the rising edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Present a start request for exactly one edge.
    task automatic start_run(input logic [2:0] m, input logic [15:0] n, input logic [15:0] p);
        i_mode       = m;
        i_nr_samples = n;
        i_period     = p;
        i_start      = 1'b1;
        tick();
        i_start      = 1'b0;
    endtask

    initial begin
        int exp_sq [6];
        checks       = 0;
        errors       = 0;
        i_rst_an     = 1'b0;
        i_ena        = 1'b0;
        i_start      = 1'b0;
        i_mode       = 3'd0;
        i_nr_samples = 16'd0;
        i_period     = 16'd0;

        // Reset state.
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_data",  o_data, 0);
        check("rst_valid", o_valid, 0);
        check("rst_busy",  o_busy, 0);
        check("rst_done",  o_done, 0);
        check("rst_cnt",   o_sample_cnt, 0);
        i_rst_an = 1'b1;
        tick();

        // Impulse, 4 samples, strobe always high.
        i_ena = 1'b1;
        start_run(3'd0, 16'd4, 16'd1);
        check("imp_busy_run", o_busy, 1);
        check("imp_valid_lat", o_valid, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("imp_data%0d", k), o_data, (k == 0) ? 127 : 0);
            check($sformatf("imp_valid%0d", k), o_valid, 1);
            check($sformatf("imp_cnt%0d", k), o_sample_cnt, k + 1);
        end
        tick();
        check("imp_done",  o_done, 1);
        check("imp_dvalid", o_valid, 0);
        check("imp_ddata", o_data, 0);
        check("imp_dcnt",  o_sample_cnt, 4);
        tick();
        check("imp_done_pulse", o_done, 0);

        // Ramp, 130 samples: wraps from 127 to -128.
        start_run(3'd2, 16'd130, 16'd1);
        for (int k = 0; k < 130; k++) begin
            tick();
            check($sformatf("ramp_data%0d", k), o_data, (k < 128) ? k : k - 256);
        end
        tick();
        check("ramp_done", o_done, 1);
        check("ramp_cnt",  o_sample_cnt, 130);

        // PRBS, 2 samples; mode and count changes mid-run are ignored.
        start_run(3'd3, 16'd2, 16'd1);
        i_mode       = 3'd2;
        i_nr_samples = 16'd9;
        tick();
        check("prbs_s0", o_data, -31);
        tick();
        check("prbs_s1", o_data, -61);
        tick();
        check("prbs_done", o_done, 1);
        check("prbs_cnt",  o_sample_cnt, 2);

        // Square, period 2, 6 samples, strobe toggling.
        exp_sq = '{127, 127, -127, -127, 127, 127};
        start_run(3'd4, 16'd6, 16'd2);
        for (int k = 0; k < 6; k++) begin
            i_ena = 1'b1;
            tick();
            check($sformatf("sq_data%0d", k), o_data, exp_sq[k]);
            check($sformatf("sq_valid%0d", k), o_valid, 1);
            if (k < 5) begin
                i_ena = 1'b0;
                tick();
                check($sformatf("sq_hold%0d", k), o_data, exp_sq[k]);
                check($sformatf("sq_gap_valid%0d", k), o_valid, 0);
            end
        end
        i_ena = 1'b1;
        tick();
        check("sq_done", o_done, 1);

        // Square with period 0 behaves as period 1.
        start_run(3'd4, 16'd3, 16'd0);
        tick();
        check("sqp0_s0", o_data, 127);
        tick();
        check("sqp0_s1", o_data, -127);
        tick();
        check("sqp0_s2", o_data, 127);
        tick();
        check("sqp0_done", o_done, 1);

        // Reserved mode emits zeros but still counts.
        start_run(3'd5, 16'd2, 16'd1);
        tick();
        check("rsv_data0",  o_data, 0);
        check("rsv_valid0", o_valid, 1);
        tick();
        check("rsv_cnt", o_sample_cnt, 2);
        tick();
        check("rsv_done", o_done, 1);

        // Zero-length run: straight to DONE with no valid sample.
        start_run(3'd0, 16'd0, 16'd1);
        check("nr0_busy",  o_busy, 1);
        check("nr0_valid", o_valid, 0);
        check("nr0_early_done", o_done, 0);
        tick();
        check("nr0_done",   o_done, 1);
        check("nr0_dvalid", o_valid, 0);
        check("nr0_cnt",    o_sample_cnt, 0);
        tick();

        // Reset mid-run after 3 of 10 ramp samples.
        start_run(3'd2, 16'd10, 16'd1);
        repeat (3) tick();
        check("mr_cnt3",  o_sample_cnt, 3);
        check("mr_data3", o_data, 2);
        i_rst_an = 1'b0;
        #1;
        check("mr_data",  o_data, 0);
        check("mr_valid", o_valid, 0);
        check("mr_busy",  o_busy, 0);
        check("mr_cnt",   o_sample_cnt, 0);
        check("mr_done",  o_done, 0);
        #2;
        i_rst_an = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("mr_nodone%0d", k), o_done, 0);
            check($sformatf("mr_novalid%0d", k), o_valid, 0);
        end

        // PRBS after reset starts again from the seed.
        start_run(3'd3, 16'd1, 16'd1);
        tick();
        check("prbs2_s0", o_data, -31);
        tick();
        check("prbs2_done", o_done, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dsp_stim_gen.md
Name: dsp_stim_gen

Overview:
On-chip stimulus source for filter blocks such as filt_fir. It produces a bounded stream of signed test samples (impulse, step, ramp, PRBS, square), one sample per cycle in which i_ena is high. It sits upstream of a filter's i_data/i_ena pair and replaces file-driven stimuli for built-in self-test.

Parameters:
gp_oup_width, 8, sample width in bits; legal range 2..16.
gp_cnt_width, 16, width of the sample-count and period fields.
gp_lfsr_seed, 16'hACE1, PRBS seed; must be non-zero. Reloaded on every start.

Ports:
i_clk  in  1  clock; all state updates on the rising edge.
i_rst_an  in  1  asynchronous reset, active low.
i_ena  in  1  sample strobe; one sample is emitted per high cycle while running.
i_start  in  1  start request; sampled only in IDLE.
i_mode  in  3  pattern: 0 impulse, 1 step, 2 ramp, 3 PRBS, 4 square, 5..7 reserved (zero).
i_nr_samples  in  gp_cnt_width  number of samples per run.
i_period  in  gp_cnt_width  square half-period in samples; 0 is treated as 1.
o_data  out  gp_oup_width  signed sample.
o_valid  out  1  o_data holds a new sample this cycle.
o_busy  out  1  high in RUN and DONE.
o_done  out  1  one-cycle pulse at the end of a run.
o_sample_cnt  out  gp_cnt_width  samples emitted in the current run.

Behaviour:
- Reset value of every output is 0. FSM resets to IDLE; LFSR resets to gp_lfsr_seed.
- MAX = 2^(W-1)-1, where W = gp_oup_width.
- IDLE:
  - o_data=0, o_valid=0.
  - When i_start=1: latch i_mode, i_nr_samples and i_period (0→1); clear the count; load the LFSR with the seed; go to RUN.
  - If the latched count is 0, go to DONE instead of RUN.
- RUN:
  - Each cycle with i_ena=1, the next sample is registered. o_data and o_valid=1 appear the following cycle (latency 1), and o_sample_cnt increments in the same update.
  - Cycles with i_ena=0: o_valid=0, o_data holds its value.
  - When the emitted count equals the latched count, go to DONE on the same edge that outputs the last sample.
- DONE (one cycle): o_done=1, o_valid=0, o_data=0, o_sample_cnt holds its final value. Then go to IDLE.
- Latched values are frozen for the whole run. i_start, i_mode, i_nr_samples and i_period changes during RUN/DONE are ignored.
- Pattern for sample k (k starts at 0):
  - impulse: MAX when k=0, else 0.
  - step: MAX.
  - ramp: k mod 2^W, taken as two's complement. It wraps 2^(W-1)-1 → -2^(W-1).
  - PRBS: 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1. Next state = {s[14:0], s15^s13^s12^s10}. Sample = s[W-1:0] as signed. The state advances after each emitted sample.
  - square: +MAX for P samples, then -MAX for P samples, repeating. P is the latched period.
  - reserved modes: 0, still counted.
- Counters wrap modulo 2^gp_cnt_width. The maximum run is 2^gp_cnt_width-1 samples.
- Reset asserted mid-run: immediate return to IDLE with all outputs 0 and no o_done pulse.
- If i_start=1 is held through DONE, a new run starts on the first IDLE cycle.

Decomposition:
- Package dsp_stim_pkg holds:
  - the mode enum (MODE_IMPULSE..MODE_SQUARE);
  - the FSM state enum (ST_IDLE, ST_RUN, ST_DONE);
  - the LFSR tap constant and default seed.
- Sub-module lfsr16 holds the 16-bit LFSR. Its inputs are i_clk, i_rst_an, load, seed and advance; its output is state.
- The pattern mux, counters and FSM stay in dsp_stim_gen.

Test Plan:
- W=8, impulse, nr=4, i_ena always 1 → o_data 127,0,0,0 with o_valid high for 4 cycles; o_done pulses the next cycle; o_sample_cnt=4.
- Ramp, nr=130 → samples 0..127, then -128, -127; then o_done.
- PRBS, seed 0xACE1, nr=2 → -31 (0xE1), then -61 (0xC3).
- Square, period=2, nr=6, i_ena toggling 1,0,1,0 → six valid samples 127,127,-127,-127,127,127; o_data holds during i_ena=0 cycles.
- nr=0 start → o_done one cycle after start with no o_valid. Changing i_mode mid-run → no effect on the pattern.
- Assert i_rst_an=0 after 3 of 10 samples → outputs 0 immediately and no o_done. The next start with PRBS produces -31 first (seed reloaded).
